imem_loader: RTL and testbench

//  Writes a program into the single-cycle CPU's instruction memory from a byte stream, holding the CPU idle until the load completes.
//  Big-endian: 4 bytes per 32-bit word, written to consecutive word addresses from 0.
//  The CPU fetches from that memory; this block is its writer.

---
 rtl/imem_loader_pkg.sv | 5 +
 rtl/imem_loader_byte_packer.sv | 29 ++
 rtl/imem_loader.sv | 90 +++++++++
 tb/tb_imem_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and word geometry.
package imem_loader_pkg;
  typedef enum logic [1:0] {IDLE, RECV, WRITE, RUN} state_t;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word shift register with a wrapping byte counter.
module byte_packer
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  clr,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_full
);
  logic [1:0] bcnt;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      word <= '0;
      bcnt <= '0;
    end else if (load) begin
      word <= {word[DATA_WIDTH-9:0], byte_in};
      bcnt <= bcnt + 2'd1;
    end
  end

  // High while the next accepted byte completes the word.
  assign word_full = (bcnt == 2'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/imem_loader.sv
// Streams a program into instruction memory, holding the CPU idle until the load completes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [DATA_WIDTH-1:0] im_wdata,
  output logic                  cpu_run,
  output logic                  done,
  output logic                  err
);
  localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   len;
  logic [ADDR_WIDTH-1:0] widx;
  logic [DATA_WIDTH-1:0] word;
  logic                  accept, word_full, last_word, pk_clr;
  logic                  start_seen, start_big, start_ok;

  assign start_seen = start && (state == IDLE || state == RUN);
  assign start_big  = load_len > CAPACITY;
  assign start_ok   = start_seen && !start_big && (load_len != '0);
  assign accept     = byte_valid && byte_ready;
  assign last_word  = ({1'b0, widx} == len - 1'b1);

  byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clock     (clock),
    .reset     (reset),
    .load      (accept),
    .clr       (pk_clr),
    .byte_in   (byte_in),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      len   <= '0;
      widx  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_seen && start_big) err <= 1'b1;
      if (start_ok) begin
        err  <= 1'b0;
        len  <= load_len;
        widx <= '0;
      end
      // Last word leaves widx on the final address, so it never wraps.
      if (state == WRITE && !last_word) widx <= widx + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    pk_clr    = 1'b0;
    case (state)
      IDLE, RUN: begin
        if (start_ok) begin
          state_nxt = RECV;
          pk_clr    = 1'b1;
        end else if (start_seen && load_len == '0) begin
          state_nxt = RUN;
        end
      end
      RECV:    if (accept && word_full) state_nxt = WRITE;
      WRITE:   state_nxt = last_word ? RUN : RECV;
      default: state_nxt = IDLE;
    endcase
  end

  assign byte_ready = (state == RECV);
  assign im_we      = (state == WRITE);
  assign cpu_run    = (state == RUN);
  assign done       = (state == RUN);
  assign im_addr    = widx;
  assign im_wdata   = word;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected IM writes are queued as words are sent.
module tb_imem_loader;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset, start, byte_valid;
  logic [AW:0]   load_len;
  logic [7:0]    byte_in;
  logic          byte_ready, im_we, cpu_run, done, err;
  logic [AW-1:0] im_addr;
  logic [DW-1:0] im_wdata;

  int compares = 0;
  int errors   = 0;
  int we_count = 0;
  logic [AW+DW-1:0] exp_q[$];

  imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .start(start), .load_len(load_len),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_run(cpu_run), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  // Every write pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (im_we === 1'b1) begin
      logic [AW+DW-1:0] exp;
      we_count++;
      compares++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL im_write unexpected: addr=%0d data=%h", im_addr, im_wdata);
      end else begin
        exp = exp_q.pop_front();
        if ({im_addr, im_wdata} !== exp) begin
          errors++;
          $display("FAIL im_write: got addr=%0d data=%h want addr=%0d data=%h",
                   im_addr, im_wdata, exp[AW+DW-1:DW], exp[DW-1:0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0;
    tick;
    reset = 1'b0;
  endtask

  task automatic pulse_start(input logic [AW:0] n);
    start = 1'b1; load_len = n;
    tick;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    byte_valid = 1'b0;
    repeat (gap) tick;
    byte_in = b; byte_valid = 1'b1;
    n = 0;
    while (byte_ready !== 1'b1 && n < 20) begin tick; n++; end
    if (n >= 20) begin
      compares++; errors++;
      $display("FAIL byte_accept timeout: byte=%h byte_ready=%b want 1", b, byte_ready);
    end else tick;
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [AW-1:0] a, input logic [31:0] w, input int gap);
    exp_q.push_back({a, w});
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], gap);
  endtask

  task automatic wait_run(input string tag);
    int n = 0;
    while (cpu_run !== 1'b1 && n < 20) begin tick; n++; end
    compares++;
    if (cpu_run !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL %s run: cpu_run=%b done=%b want 1 1", tag, cpu_run, done);
    end
    compares++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending_writes: %0d left want 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_count(input string tag, input int got, input int want);
    compares++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s we_count: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic test_reset;
    do_reset;
    compares++;
    if ({byte_ready, im_we, cpu_run, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000", {byte_ready, im_we, cpu_run, done, err});
    end
    compares++;
    if ({im_addr, im_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_bus: addr=%0d data=%h want 0 0", im_addr, im_wdata);
    end
  endtask

  task automatic test_load3;
    int c = we_count;
    do_reset;
    pulse_start(6'd3);
    compares++;
    if (cpu_run !== 1'b0 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL load3_recv: cpu_run=%b byte_ready=%b want 0 1", cpu_run, byte_ready);
    end
    send_word(5'd0, 32'h2001ffff, 0);
    send_word(5'd1, 32'h20020064, 0);
    send_word(5'd2, 32'h00221820, 0);
    wait_run("load3");
    check_count("load3", we_count - c, 3);
  endtask

  task automatic test_toggle;
    int c = we_count;
    do_reset;
    pulse_start(6'd3);
    send_word(5'd0, 32'h2001ffff, 1);
    // start during a load must be ignored
    start = 1'b1; load_len = 6'd7;
    tick;
    start = 1'b0;
    send_word(5'd1, 32'h20020064, 1);
    send_word(5'd2, 32'h00221820, 1);
    wait_run("toggle");
    check_count("toggle", we_count - c, 3);
  endtask

  task automatic test_oversize;
    do_reset;
    pulse_start(6'd33);
    tick;
    compares++;
    if (err !== 1'b1 || byte_ready !== 1'b0 || cpu_run !== 1'b0) begin
      errors++;
      $display("FAIL oversize: err=%b byte_ready=%b cpu_run=%b want 1 0 0", err, byte_ready, cpu_run);
    end
    pulse_start(6'd1);
    compares++;
    if (err !== 1'b0 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL oversize_clear: err=%b byte_ready=%b want 0 1", err, byte_ready);
    end
    send_word(5'd0, 32'hdeadbeef, 0);
    wait_run("oversize");
  endtask

  task automatic test_zero;
    int c;
    do_reset;
    c = we_count;
    pulse_start(6'd0);
    compares++;
    if (cpu_run !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL zero_len: cpu_run=%b done=%b want 1 1", cpu_run, done);
    end
    repeat (3) tick;
    check_count("zero_len", we_count - c, 0);
  endtask

  task automatic test_reset_midload;
    int c;
    do_reset;
    c = we_count;
    pulse_start(6'd2);
    send_word(5'd0, 32'h11223344, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    do_reset;
    compares++;
    if ({byte_ready, im_we, cpu_run, done, err, im_addr, im_wdata} !== '0) begin
      errors++;
      $display("FAIL midload_reset: flags=%b addr=%0d data=%h want all 0",
               {byte_ready, im_we, cpu_run, done, err}, im_addr, im_wdata);
    end
    byte_valid = 1'b1; byte_in = 8'h77;
    repeat (5) tick;
    byte_valid = 1'b0;
    check_count("midload", we_count - c, 1);
    compares++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL midload pending_writes: %0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_run_reload;
    do_reset;
    pulse_start(6'd0);
    pulse_start(6'd40);
    compares++;
    if (err !== 1'b1 || cpu_run !== 1'b1) begin
      errors++;
      $display("FAIL run_oversize: err=%b cpu_run=%b want 1 1", err, cpu_run);
    end
    pulse_start(6'd1);
    compares++;
    if (cpu_run !== 1'b0 || done !== 1'b0 || byte_ready !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL reload: cpu_run=%b done=%b byte_ready=%b err=%b want 0 0 1 0",
               cpu_run, done, byte_ready, err);
    end
    send_word(5'd0, 32'h00000000, 0);
    wait_run("reload");
  endtask

  task automatic test_full;
    int c;
    do_reset;
    c = we_count;
    pulse_start(6'd32);
    for (int a = 0; a < 32; a++) send_word(5'(a), $urandom, 0);
    wait_run("full");
    check_count("full", we_count - c, 32);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = '0; load_len = '0;
    test_reset;
    test_load3;
    test_toggle;
    test_oversize;
    test_zero;
    test_reset_midload;
    test_run_reload;
    test_full;
    repeat (2) tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end
endmodule
